// File: rtl/cmd_serial_receiver_pkg.sv
// Shared definitions for the command receiver: default command width and drain FSM states.
`timescale 1ns/1ps
package cmd_rx_defs;

   localparam int CMD_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HIGH  = 2'd2,
      GAP   = 2'd3
   } drain_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
`timescale 1ns/1ps
module cmd_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

   // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cmd_serial_receiver.sv
// Deserialises SPI-style command words into a FIFO and replays each one on cmd_data
// with a single, well-spaced latch_data pulse.
`timescale 1ns/1ps
module cmd_serial_receiver
   import cmd_rx_defs::*;
#(
   parameter int WORD_WIDTH  = CMD_WORD_WIDTH,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LATCH_HIGH  = 2,
   parameter int LATCH_GAP   = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          spi_sclk,
   input  logic                          spi_cs_n,
   input  logic                          spi_mosi,
   input  logic                          clear_status,
   output logic [WORD_WIDTH-1:0]         cmd_data,
   output logic                          latch_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          frame_error
);

   localparam int BW     = $clog2(WORD_WIDTH);
   localparam int CNT_MAX = (LATCH_HIGH > LATCH_GAP) ? LATCH_HIGH : LATCH_GAP;
   localparam int CW     = $clog2(CNT_MAX + 1);

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_s, cs_s, mosi_s;
   logic                   sclk_prev, cs_prev;

   logic [BW-1:0]          bit_cnt;
   logic [WORD_WIDTH-1:0]  shift_reg;
   logic [WORD_WIDTH-1:0]  shift_next;
   logic                   sclk_edge;
   logic                   word_done;
   logic                   frame_err_set;
   logic                   ovf_set;

   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [WORD_WIDTH-1:0]  fifo_head;

   drain_state_t           state;
   logic [CW-1:0]          phase_cnt;

   // Presets make an idle link look idle (sclk low, cs deasserted) straight out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
      end
   end

   assign sclk_s        = sclk_sync[SYNC_STAGES-1];
   assign cs_s          = cs_sync[SYNC_STAGES-1];
   assign mosi_s        = mosi_sync[SYNC_STAGES-1];
   assign sclk_edge     = sclk_s && !sclk_prev && !cs_s;
   assign word_done     = sclk_edge && (bit_cnt == BW'(WORD_WIDTH - 1));
   assign shift_next    = {shift_reg[WORD_WIDTH-2:0], mosi_s};
   assign frame_err_set = cs_s && !cs_prev && (bit_cnt != '0);
   assign ovf_set       = word_done && fifo_full && !fifo_pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (cs_s) begin
         bit_cnt <= '0;
      end else if (sclk_edge) begin
         shift_reg <= shift_next;
         bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
      end
   end

   // Set events take priority over a coincident clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         if (ovf_set)            overflow <= 1'b1;
         else if (clear_status)  overflow <= 1'b0;
         if (frame_err_set)      frame_error <= 1'b1;
         else if (clear_status)  frame_error <= 1'b0;
      end
   end

   cmd_fifo #(
      .WIDTH (WORD_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (word_done),
      .pop   (fifo_pop),
      .wdata (shift_next),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign fifo_pop = (state == IDLE) && !fifo_empty;

   // SETUP gives cmd_data one quiet cycle before the strobe rises.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cmd_data   <= '0;
         latch_data <= 1'b0;
         phase_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  cmd_data <= fifo_head;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               latch_data <= 1'b1;
               phase_cnt  <= '0;
               state      <= HIGH;
            end
            HIGH: begin
               if (phase_cnt == CW'(LATCH_HIGH - 1)) begin
                  latch_data <= 1'b0;
                  phase_cnt  <= '0;
                  state      <= GAP;
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
               end
            end
            GAP: begin
               if (phase_cnt == CW'(LATCH_GAP - 1)) state <= IDLE;
               else                                 phase_cnt <= phase_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_serial_receiver.sv
// Bench for cmd_serial_receiver: a default instance for framing/latency/reset behaviour and
// a slow-drain instance that makes FIFO overflow reachable.
`timescale 1ns/1ps
module tb_cmd_serial_receiver;

   localparam int LATCH_HIGH   = 2;
   localparam int LATCH_GAP    = 2;
   localparam int SLOW_HIGH    = 2500;
   localparam int FIFO_DEPTH   = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reset_q = 1'b1;
   int          cyc = 0;

   logic        a_sclk = 1'b0, a_cs_n = 1'b1, a_mosi = 1'b0, a_clear = 1'b0;
   logic [31:0] a_cmd_data;
   logic        a_latch, a_ovf, a_ferr;
   logic [2:0]  a_level;

   logic        b_sclk = 1'b0, b_cs_n = 1'b1, b_mosi = 1'b0, b_clear = 1'b0;
   logic [31:0] b_cmd_data;
   logic        b_latch, b_ovf, b_ferr;
   logic [2:0]  b_level;

   int checks = 0;
   int errors = 0;

   // Expected delivery order for each instance
   logic [31:0] a_exp_q[$];
   logic [31:0] b_exp_q[$];
   int          b_model_cnt = 0;
   logic        b_exp_ovf = 1'b0;

   int          last_rise_cyc = 0;
   int          a_rise_cyc = 0;
   int          a_pulse_cnt = 0;
   int          b_pulse_cnt = 0;

   cmd_serial_receiver dut_a (
      .clock        (clock),
      .reset        (reset),
      .spi_sclk     (a_sclk),
      .spi_cs_n     (a_cs_n),
      .spi_mosi     (a_mosi),
      .clear_status (a_clear),
      .cmd_data     (a_cmd_data),
      .latch_data   (a_latch),
      .fifo_level   (a_level),
      .overflow     (a_ovf),
      .frame_error  (a_ferr)
   );

   cmd_serial_receiver #(.LATCH_HIGH(SLOW_HIGH)) dut_b (
      .clock        (clock),
      .reset        (reset),
      .spi_sclk     (b_sclk),
      .spi_cs_n     (b_cs_n),
      .spi_mosi     (b_mosi),
      .clear_status (b_clear),
      .cmd_data     (b_cmd_data),
      .latch_data   (b_latch),
      .fifo_level   (b_level),
      .overflow     (b_ovf),
      .frame_error  (b_ferr)
   );

   // clock/reset
   always #5 clock = ~clock;
   always @(posedge clock) begin
      cyc     <= cyc + 1;
      reset_q <= reset;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // drivers
   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_pins(input bit sel, input logic sclk, input logic cs_n, input logic mosi);
      if (sel) begin b_sclk = sclk; b_cs_n = cs_n; b_mosi = mosi; end
      else     begin a_sclk = sclk; a_cs_n = cs_n; a_mosi = mosi; end
   endtask

   task automatic cs_low(input bit sel);
      set_pins(sel, 1'b0, 1'b0, 1'b0);
      tick(4);
   endtask

   task automatic cs_high(input bit sel);
      set_pins(sel, 1'b0, 1'b1, 1'b0);
      tick(4);
   endtask

   // Sends the top nbits of word, MSB first; every sclk phase lasts 3..4 clocks.
   task automatic send_bits(input bit sel, input logic [31:0] word, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         set_pins(sel, 1'b0, 1'b0, word[31-i]);
         tick($urandom_range(3, 4));
         set_pins(sel, 1'b1, 1'b0, word[31-i]);
         last_rise_cyc = cyc;
         tick($urandom_range(3, 4));
      end
      set_pins(sel, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_frame_a(input int nwords);
      logic [31:0] w;
      cs_low(0);
      for (int k = 0; k < nwords; k++) begin
         w = $urandom;
         a_exp_q.push_back(w);
         send_bits(0, w, 32);
      end
      cs_high(0);
   endtask

   task automatic wait_drain_a(input int budget);
      int n;
      n = 0;
      while ((a_exp_q.size() != 0 || a_latch) && n < budget) begin
         tick(1);
         n++;
      end
      check("a_drain_done", a_exp_q.size(), 0);
      tick(LATCH_GAP + 2);
   endtask

   // B-side model: word is taken while the drain is busy only if buffer room remains.
   task automatic send_b_modelled(input logic [31:0] w);
      if (b_model_cnt < FIFO_DEPTH) begin
         b_exp_q.push_back(w);
         b_model_cnt++;
      end else begin
         b_exp_ovf = 1'b1;
      end
      send_bits(1, w, 32);
   endtask

   // scoreboard monitors: pulse shape, spacing, data order and stability
   int          a_high_len = 0, a_low_len = 100;
   logic        a_prev = 1'b0, a_stable = 1'b1;
   logic [31:0] a_hold = '0;
   int          b_high_len = 0;
   logic        b_prev = 1'b0;

   always @(negedge clock) begin
      if (reset_q) begin
         a_prev = 1'b0; a_high_len = 0; a_low_len = 100;
         b_prev = 1'b0; b_high_len = 0;
      end else begin
         if (a_latch && !a_prev) begin
            a_rise_cyc = cyc;
            a_pulse_cnt++;
            check("a_gap_low", 32'(a_low_len >= LATCH_GAP), 32'd1);
            if (a_exp_q.size() == 0) check("a_pulse_expected", 32'd0, 32'd1);
            else                     check("a_cmd_data", a_cmd_data, a_exp_q.pop_front());
            a_hold = a_cmd_data; a_stable = 1'b1; a_high_len = 1;
         end else if (a_latch) begin
            a_high_len++;
            if (a_cmd_data !== a_hold) a_stable = 1'b0;
         end else if (a_prev) begin
            check("a_high_len", 32'(a_high_len), 32'(LATCH_HIGH));
            check("a_data_stable", 32'(a_stable), 32'd1);
            a_low_len = 1;
         end else begin
            a_low_len++;
         end
         a_prev = a_latch;

         if (b_latch && !b_prev) begin
            b_pulse_cnt++;
            if (b_exp_q.size() == 0) check("b_pulse_expected", 32'd0, 32'd1);
            else                     check("b_cmd_data", b_cmd_data, b_exp_q.pop_front());
            b_high_len = 1;
         end else if (b_latch) begin
            b_high_len++;
         end else if (b_prev) begin
            check("b_high_len", 32'(b_high_len), 32'(SLOW_HIGH));
         end
         b_prev = b_latch;
      end
   end

   initial begin
      int n;
      int t1_rise;
      logic [31:0] w;

      tick(3);
      check("rst_latch", 32'(a_latch), 32'd0);
      check("rst_cmd_data", a_cmd_data, 32'd0);
      check("rst_level", 32'(a_level), 32'd0);
      check("rst_flags", {30'd0, a_ovf, a_ferr}, 32'd0);
      reset = 1'b0;
      tick(3);

      // Single run-state command: latency and pulse shape
      a_exp_q.push_back(32'hC800_0000);
      cs_low(0);
      send_bits(0, 32'hC800_0000, 32);
      t1_rise = last_rise_cyc;
      cs_high(0);
      wait_drain_a(200);
      check("t1_latency", 32'(a_rise_cyc - t1_rise), 32'd5);
      check("t1_pulses", 32'(a_pulse_cnt), 32'd1);
      check("t1_level", 32'(a_level), 32'd0);

      // Three words in one frame
      cs_low(0);
      a_exp_q.push_back(32'h0001_1234); send_bits(0, 32'h0001_1234, 32);
      a_exp_q.push_back(32'h4400_ABCD); send_bits(0, 32'h4400_ABCD, 32);
      a_exp_q.push_back(32'h8040_0155); send_bits(0, 32'h8040_0155, 32);
      cs_high(0);
      wait_drain_a(200);
      check("t2_pulses", 32'(a_pulse_cnt), 32'd4);
      check("t2_no_flags", {30'd0, a_ovf, a_ferr}, 32'd0);

      // Partial frame, then a good word
      cs_low(0);
      send_bits(0, $urandom, 17);
      cs_high(0);
      check("t4_frame_error", 32'(a_ferr), 32'd1);
      a_exp_q.push_back(32'h1234_5678);
      cs_low(0);
      send_bits(0, 32'h1234_5678, 32);
      cs_high(0);
      wait_drain_a(200);
      check("t4_pulses", 32'(a_pulse_cnt), 32'd5);
      check("t4_ferr_sticky", 32'(a_ferr), 32'd1);
      a_clear = 1'b1; tick(1); a_clear = 1'b0; tick(1);
      check("t4_ferr_cleared", 32'(a_ferr), 32'd0);

      // Reset mid-word
      cs_low(0);
      send_bits(0, $urandom, 10);
      reset = 1'b1; tick(1);
      check("t5a_cmd_data", a_cmd_data, 32'd0);
      check("t5a_level", 32'(a_level), 32'd0);
      reset = 1'b0;
      cs_high(0);
      check("t5a_flags", {30'd0, a_ovf, a_ferr}, 32'd0);

      // Reset while latch_data is high
      w = $urandom;
      a_exp_q.push_back(w);
      cs_low(0);
      send_bits(0, w, 32);
      n = 0;
      while (!a_latch && n < 50) begin tick(1); n++; end
      check("t5b_latch_seen", 32'(a_latch), 32'd1);
      reset = 1'b1; tick(1);
      check("t5b_latch", 32'(a_latch), 32'd0);
      check("t5b_cmd_data", a_cmd_data, 32'd0);
      check("t5b_level", 32'(a_level), 32'd0);
      reset = 1'b0;
      cs_high(0);
      check("t5b_flags", {30'd0, a_ovf, a_ferr}, 32'd0);
      send_frame_a(1);
      wait_drain_a(200);

      // Randomised frames of one to three words
      for (int f = 0; f < 4; f++) begin
         send_frame_a($urandom_range(1, 3));
         wait_drain_a(300);
      end
      check("rand_level", 32'(a_level), 32'd0);
      check("rand_flags", {30'd0, a_ovf, a_ferr}, 32'd0);

      // Overflow on the slow-drain instance: a dummy word keeps the drain busy
      b_exp_q.push_back(32'hDEAD_0001);
      cs_low(1);
      send_bits(1, 32'hDEAD_0001, 32);
      n = 0;
      while (!b_latch && n < 50) begin tick(1); n++; end
      check("t3_drain_busy", 32'(b_latch), 32'd1);
      for (int k = 0; k < FIFO_DEPTH + 1; k++) send_b_modelled($urandom);
      tick(4);
      check("t3_overflow", 32'(b_ovf), 32'(b_exp_ovf));
      check("t3_level", 32'(b_level), 32'(FIFO_DEPTH));
      b_clear = 1'b1; tick(1); b_clear = 1'b0; tick(1);
      check("t3_ovf_cleared", 32'(b_ovf), 32'd0);

      // Clear coincident with a drop: the 32nd edge is pushed two clocks after sync
      w = $urandom;
      send_bits(1, w, 31);
      set_pins(1, 1'b0, 1'b0, w[0]);
      tick(3);
      set_pins(1, 1'b1, 1'b0, w[0]);
      tick(2);
      b_clear = 1'b1; tick(1); b_clear = 1'b0;
      tick(3);
      set_pins(1, 1'b0, 1'b0, 1'b0);
      check("t6_set_wins", 32'(b_ovf), 32'd1);
      check("t6_level", 32'(b_level), 32'(FIFO_DEPTH));
      cs_high(1);

      n = 0;
      while ((b_exp_q.size() != 0 || b_latch) && n < 15000) begin tick(1); n++; end
      check("b_drain_done", b_exp_q.size(), 0);
      check("b_pulses", 32'(b_pulse_cnt), 32'(FIFO_DEPTH + 1));
      tick(4);
      check("b_level_end", 32'(b_level), 32'd0);
      check("b_ferr", 32'(b_ferr), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
